vga_timing_ctrl: RTL and testbench
==================================

# vga_timing_ctrl

Sequencer for the 25 MHz pixel-rate datapath: derives a one-in-four pixel tick from the 100 MHz system clock and drives the 640x480@60 VGA raster counters, sync pulses and blanking. Sits between the system clock domain and the pixel/RGB generation logic. Supports orderly start/stop on frame boundaries through a run/stop handshake.

## Interface
Parameters:
- DIV, 4, clkIn cycles per pixel tick (≥2)
- H_ACTIVE, 640; H_FP, 16; H_SYNC, 96; H_BP, 48: horizontal timing, in pixels
- V_ACTIVE, 480; V_FP, 10; V_SYNC, 2; V_BP, 33: vertical timing, in lines

Ports:
- clkIn  in  1  system clock, 100 MHz
- reset  in  1  asynchronous, active-low reset; asserted when 0
- en  in  1  run request; level-sensitive
- pix_tick  out  1  pixel-rate enable, high 1 clkIn cycle in every DIV
- hsync  out  1  horizontal sync, active-low
- vsync  out  1  vertical sync, active-low
- video_on  out  1  high inside the active area
- x  out  10  current pixel column
- y  out  10  current line
- frame_start  out  1  one-clkIn-cycle pulse at each frame origin
- busy  out  1  high in RUN or STOP_PEND

## Operation
- Tick counter counts 0..DIV-1 continuously; pix_tick = (count == DIV-1); wraps to 0 after DIV-1. It runs in every state.
- H_TOTAL = 800, V_TOTAL = 525, both derived from the parameters. h and v are 10-bit counters and advance only on edges where pix_tick = 1.
- h wraps H_TOTAL-1 -> 0 and increments v. v wraps V_TOTAL-1 -> 0.
- x = h and y = v.
- video_on = (h < H_ACTIVE) && (v < V_ACTIVE).
- hsync is low for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], i.e. [656,751].
- vsync is low for v in [490,491].
- State machine:
  - IDLE: h = v = 0, hsync = vsync = 1, video_on = 0. On en = 1, go to RUN at the next pix_tick edge, with the counters at (0,0).
  - RUN: counters advance. en = 0 goes to STOP_PEND.
  - STOP_PEND: counters keep advancing. en = 1 returns to RUN with no discontinuity. A tick at (799,524) with en = 0 goes to IDLE and leaves the counters at (0,0).
- frame_start pulses when the counters load (0,0) while entering or continuing RUN. It does not pulse on entry to IDLE.
- Simultaneous events: en toggling within one tick period is sampled only on pix_tick edges. The last value sampled wins.

## Timing
- Reset values: tick count 0, state IDLE, h = v = 0, x = y = 0, hsync = 1, vsync = 1, video_on = 0, pix_tick = 0, frame_start = 0, busy = 0.
- All outputs are registered. hsync, vsync, video_on and x/y change only on pix_tick edges and are mutually aligned with zero skew.
- Start latency: at most DIV clkIn cycles from en = 1 to the first RUN tick.
- frame_start is high for the clkIn cycle that follows the (0,0) update.
- Line period = 800 × DIV = 3200 clkIn cycles. Frame period = 1,680,000 clkIn cycles.
- Reset asserted mid-frame: all state returns to reset values immediately (asynchronous). After release, the block waits for en.

## Configuration
- VGA_FRAME_CNT_EN defined: adds output port frame_cnt (out, 16 bits). It resets to 0, increments on each frame_start, wraps 65535 -> 0, and holds its value in IDLE.
- VGA_FRAME_CNT_EN undefined: the port and its counter are absent. All other behaviour is identical.

## Structure
- Package vga_timing_pkg holds:
  - the default timing constants, plus H_TOTAL and V_TOTAL;
  - the 10-bit coordinate typedef;
  - the state enum {IDLE, RUN, STOP_PEND}.
- Sub-module pix_tick_gen is the DIV-parameterised tick counter with reset, producing pix_tick.
- The raster counters and FSM are kept in vga_timing_ctrl.

## Test plan
- Reset release with en = 0 for 100 cycles -> hsync = vsync = 1, video_on = 0, busy = 0, and pix_tick pulses every 4th cycle.
- en = 1 -> within 4 cycles busy = 1 and frame_start pulses once. x counts 0..799, and video_on falls at x = 640.
- Line check -> hsync low exactly 96 ticks, from x = 656 to x = 751. The line repeats every 3200 clkIn cycles.
- Frame check -> vsync low for y = 490..491. frame_start interval is exactly 1,680,000 cycles.
- en = 0 at y = 100 -> the frame completes, the block enters IDLE at (0,0) with busy = 0 and no extra frame_start. Re-asserting en during STOP_PEND keeps the raster continuous.
- Reset pulse at y = 300 -> all outputs immediately return to reset values. With VGA_FRAME_CNT_EN defined, frame_cnt = 0 after reset and equals 3 after three frames.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared timing defaults, coordinate type and sequencer states for the VGA raster block.
package vga_timing_pkg;

    localparam int VGA_DIV      = 4;
    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    localparam int H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    typedef logic [9:0] coord_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RUN       = 2'd1,
        STOP_PEND = 2'd2
    } state_t;

    // Inclusive window test used for both sync pulses.
    function automatic logic in_window(input coord_t c, input coord_t lo, input coord_t hi);
        return (c >= lo) && (c <= hi);
    endfunction

endpackage

// File: rtl/vga_timing_ctrl_pix_tick_gen.sv
// Free-running divide-by-DIV counter producing a registered one-cycle pixel enable.
module pix_tick_gen #(
    parameter int DIV = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    output logic o_pix_tick
);

    localparam int CW = (DIV <= 2) ? 1 : $clog2(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] PRE  = CW'(DIV - 2);

    logic [CW-1:0] r_cnt;
    logic          r_tick;

    // The tick is registered one count early so it is high exactly while r_cnt == DIV-1.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_cnt  <= (r_cnt == LAST) ? '0 : r_cnt + CW'(1);
            r_tick <= (r_cnt == PRE);
        end
    end

    assign o_pix_tick = r_tick;

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA raster sequencer: pixel tick, h/v counters, syncs, blanking and run/stop FSM.
// Optional `VGA_FRAME_CNT_EN adds a 16-bit frame_cnt output counting frame_start pulses.
module vga_timing_ctrl
    import vga_timing_pkg::*;
#(
    parameter int DIV      = VGA_DIV,
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP
) (
    input  logic        clkIn,
    input  logic        reset,
    input  logic        en,
    output logic        pix_tick,
    output logic        hsync,
    output logic        vsync,
    output logic        video_on,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic        frame_start,
    output logic        busy
`ifdef VGA_FRAME_CNT_EN
    ,
    output logic [15:0] frame_cnt
`endif
);

    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam coord_t H_LAST   = coord_t'(H_TOT - 1);
    localparam coord_t V_LAST   = coord_t'(V_TOT - 1);
    localparam coord_t H_ACT_C  = coord_t'(H_ACTIVE);
    localparam coord_t V_ACT_C  = coord_t'(V_ACTIVE);
    localparam coord_t HS_FIRST = coord_t'(H_ACTIVE + H_FP);
    localparam coord_t HS_LAST  = coord_t'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam coord_t VS_FIRST = coord_t'(V_ACTIVE + V_FP);
    localparam coord_t VS_LAST  = coord_t'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic   w_pix_tick;
    state_t r_state;
    coord_t r_h;
    coord_t r_v;
    logic   r_hsync;
    logic   r_vsync;
    logic   r_video_on;
    logic   r_frame_start;
    logic   r_busy;

    state_t w_state_nxt;
    coord_t w_h_nxt;
    coord_t w_v_nxt;
    coord_t w_h_adv;
    coord_t w_v_adv;
    logic   w_line_end;
    logic   w_frame_end;
    logic   w_fs_nxt;
    logic   w_active;

    pix_tick_gen #(
        .DIV (DIV)
    ) u_tick (
        .i_clk      (clkIn),
        .i_rst_n    (reset),
        .o_pix_tick (w_pix_tick)
    );

    assign w_line_end  = (r_h == H_LAST);
    assign w_frame_end = w_line_end && (r_v == V_LAST);
    assign w_h_adv     = w_line_end ? '0 : r_h + coord_t'(1);
    assign w_v_adv     = !w_line_end ? r_v : ((r_v == V_LAST) ? '0 : r_v + coord_t'(1));

    // en is only acted on at tick edges; between ticks everything holds.
    always_comb begin
        w_state_nxt = r_state;
        w_h_nxt     = r_h;
        w_v_nxt     = r_v;
        w_fs_nxt    = 1'b0;
        if (w_pix_tick) begin
            case (r_state)
                IDLE: begin
                    if (en) begin
                        w_state_nxt = RUN;
                        w_h_nxt     = '0;
                        w_v_nxt     = '0;
                        w_fs_nxt    = 1'b1;
                    end
                end
                RUN, STOP_PEND: begin
                    if (w_frame_end && !en) begin
                        w_state_nxt = IDLE;
                        w_h_nxt     = '0;
                        w_v_nxt     = '0;
                    end else begin
                        w_state_nxt = en ? RUN : STOP_PEND;
                        w_h_nxt     = w_h_adv;
                        w_v_nxt     = w_v_adv;
                        w_fs_nxt    = w_frame_end;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_h_nxt     = '0;
                    w_v_nxt     = '0;
                end
            endcase
        end
    end

    assign w_active = (w_state_nxt != IDLE);

    // Syncs and blanking are decoded from the next coordinates so they land with x/y.
    always_ff @(posedge clkIn or negedge reset) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_h           <= '0;
            r_v           <= '0;
            r_hsync       <= 1'b1;
            r_vsync       <= 1'b1;
            r_video_on    <= 1'b0;
            r_frame_start <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_h           <= w_h_nxt;
            r_v           <= w_v_nxt;
            r_hsync       <= !(w_active && in_window(w_h_nxt, HS_FIRST, HS_LAST));
            r_vsync       <= !(w_active && in_window(w_v_nxt, VS_FIRST, VS_LAST));
            r_video_on    <= w_active && (w_h_nxt < H_ACT_C) && (w_v_nxt < V_ACT_C);
            r_frame_start <= w_fs_nxt;
            r_busy        <= w_active;
        end
    end

`ifdef VGA_FRAME_CNT_EN
    logic [15:0] r_frame_cnt;

    always_ff @(posedge clkIn or negedge reset) begin
        if (!reset) begin
            r_frame_cnt <= '0;
        end else if (w_fs_nxt) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    assign frame_cnt = r_frame_cnt;
`endif

    assign pix_tick    = w_pix_tick;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign video_on    = r_video_on;
    assign x           = r_h;
    assign y           = r_v;
    assign frame_start = r_frame_start;
    assign busy        = r_busy;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Randomized bench for vga_timing_ctrl against a linear-pixel-index reference model.
// Uses a shrunken raster so several full frames fit in a short run.
module tb_vga_timing_ctrl;

    localparam int DIV = 4;
    localparam int HA = 16, HF = 4, HS = 6, HB = 6;
    localparam int VA = 12, VF = 2, VS = 2, VB = 3;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FR = HT * VT;
    localparam logic [31:0] RST_VEC = 32'h0180_0000;

    logic        clkIn = 1'b0;
    logic        reset = 1'b0;
    logic        en    = 1'b0;
    logic        pix_tick, hsync, vsync, video_on, frame_start, busy;
    logic [9:0]  x, y;
`ifdef VGA_FRAME_CNT_EN
    logic [15:0] frame_cnt;
`endif

    int total = 0;
    int bad   = 0;

    // Reference model: cycles since reset release, run flag, linear pixel index in frame.
    int k      = 0;
    bit m_run  = 1'b0;
    int m_p    = 0;
    bit m_fs   = 1'b0;
    int m_fcnt = 0;

    vga_timing_ctrl #(
        .DIV(DIV), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut (
        .clkIn       (clkIn),
        .reset       (reset),
        .en          (en),
        .pix_tick    (pix_tick),
        .hsync       (hsync),
        .vsync       (vsync),
        .video_on    (video_on),
        .x           (x),
        .y           (y),
        .frame_start (frame_start),
        .busy        (busy)
`ifdef VGA_FRAME_CNT_EN
        ,
        .frame_cnt   (frame_cnt)
`endif
    );

    always #5 clkIn = ~clkIn;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        k = 0; m_run = 1'b0; m_p = 0; m_fs = 1'b0; m_fcnt = 0;
    endtask

    task automatic model_step();
        if (!reset) begin
            model_reset();
        end else begin
            m_fs = 1'b0;
            if (k % DIV == DIV - 1) begin
                if (!m_run) begin
                    if (en) begin
                        m_run = 1'b1; m_p = 0; m_fs = 1'b1;
                    end
                end else if (m_p == FR - 1 && !en) begin
                    m_run = 1'b0; m_p = 0;
                end else begin
                    m_p  = (m_p + 1) % FR;
                    m_fs = (m_p == 0);
                end
            end
            k++;
            if (m_fs) m_fcnt = (m_fcnt + 1) % 65536;
        end
    endtask

    function automatic logic [31:0] exp_vec();
        int xh, yv;
        logic pt, hs_n, vs_n, von;
        xh   = m_p % HT;
        yv   = m_p / HT;
        pt   = ((k % DIV) == DIV - 1);
        hs_n = !(m_run && xh >= HA + HF && xh <= HA + HF + HS - 1);
        vs_n = !(m_run && yv >= VA + VF && yv <= VA + VF + VS - 1);
        von  = m_run && (xh < HA) && (yv < VA);
        return {6'b0, pt, hs_n, vs_n, von, m_run, m_fs, xh[9:0], yv[9:0]};
    endfunction

    function automatic logic [31:0] obs_vec();
        return {6'b0, pix_tick, hsync, vsync, video_on, busy, frame_start, x, y};
    endfunction

    task automatic summary_and_finish();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    endtask

    task automatic cycle();
        @(posedge clkIn);
        model_step();
        #1;
        check_eq("cyc", obs_vec(), exp_vec());
`ifdef VGA_FRAME_CNT_EN
        check_eq("fcnt", {16'b0, frame_cnt}, m_fcnt);
`endif
        if (bad > 50) summary_and_finish();
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic wait_row(input int row);
        int cnt;
        cnt = 0;
        while (y != 10'(row) && cnt < 2 * FR * DIV) begin
            cycle();
            cnt++;
        end
        check_eq("wait_row", {22'b0, y}, row);
    endtask

    initial begin
        int lat, fs_n, last_fs, hs_lo, vs_lo, von_n, cnt, fs_seen, hold;

        run_cycles(3);
        check_eq("reset_vals", obs_vec(), RST_VEC);
        @(negedge clkIn) reset = 1'b1;

        // Idle with en low: syncs high, no activity, tick cadence checked by model.
        run_cycles(100);
        check_eq("idle_busy", {31'b0, busy}, 0);

        // Start: busy and the first frame_start within DIV cycles.
        run_cycles($urandom_range(0, 3));
        en  = 1'b1;
        lat = 0;
        do begin
            cycle();
            lat++;
        end while (!busy && lat < 4 * DIV);
        check_eq("start_lat", {31'b0, (lat <= DIV)}, 1);
        check_eq("start_fs", {31'b0, frame_start}, 1);

        // Three continuous frames: pulse spacing and per-frame sync/blank totals.
        fs_n = 0; last_fs = 0; hs_lo = 0; vs_lo = 0; von_n = 0;
        for (int i = 1; i <= 3 * FR * DIV; i++) begin
            cycle();
            if (frame_start) begin
                fs_n++;
                check_eq("fs_interval", i - last_fs, FR * DIV);
                last_fs = i;
            end
            if (!hsync) hs_lo++;
            if (!vsync) vs_lo++;
            if (video_on) von_n++;
        end
        check_eq("fs_count", fs_n, 3);
        check_eq("hsync_low", hs_lo, 3 * VT * HS * DIV);
        check_eq("vsync_low", vs_lo, 3 * VS * HT * DIV);
        check_eq("video_on", von_n, 3 * HA * VA * DIV);

        // Brief stop request withdrawn before the frame ends: raster must not jump.
        wait_row(3);
        en = 1'b0;
        run_cycles(5 * DIV);
        en = 1'b1;
        run_cycles(HT * DIV);

        // Stop mid-frame: frame completes, then idle at origin with no extra pulse.
        wait_row(VT / 2);
        en = 1'b0;
        fs_seen = 0;
        cnt = 0;
        while (busy && cnt < 2 * FR * DIV) begin
            cycle();
            if (frame_start) fs_seen++;
            cnt++;
        end
        check_eq("stop_idle", {11'b0, busy, x, y}, 0);
        check_eq("stop_fs", fs_seen, 0);
        run_cycles(50);

        // Random en patterns, including glitches shorter than a tick period.
        for (int s = 0; s < 60; s++) begin
            en   = 1'($urandom_range(0, 1));
            hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(20, 600);
            run_cycles(hold);
        end

        // Asynchronous reset mid-frame.
        en = 1'b1;
        cnt = 0;
        while (!busy && cnt < 4 * DIV) begin
            cycle();
            cnt++;
        end
        wait_row(8);
        #2 reset = 1'b0;
        model_reset();
        #1;
        check_eq("async_rst", obs_vec(), RST_VEC);
`ifdef VGA_FRAME_CNT_EN
        check_eq("fcnt_rst", {16'b0, frame_cnt}, 0);
`endif
        run_cycles(4);
        @(negedge clkIn) reset = 1'b1;
        en = 1'b0;
        run_cycles(40);
        check_eq("post_rst_idle", {31'b0, busy}, 0);
        en = 1'b1;
        run_cycles(2 * FR * DIV + 2 * DIV);
`ifdef VGA_FRAME_CNT_EN
        check_eq("fcnt_three", {16'b0, frame_cnt}, 3);
`endif
        check_eq("run_busy", {31'b0, busy}, 1);

        summary_and_finish();
    end

endmodule
